// File: rtl/ntt_pkg.sv
// Shared NTT constants, unloader FSM state type and the conflict-free
// memory map used by both the loader/unloader and the NTT address path.
package ntt_pkg;

  localparam int unsigned ntt_data_width = 14;
  localparam int unsigned ntt_addr_width = 7;
  localparam int unsigned ntt_n_coeff    = 512;
  localparam int unsigned ntt_n_banks    = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } unload_state_t;

  // Bank = sum of the 2-bit digits of the index (top bit alone) mod 4.
  function automatic logic [1:0] map_bank(input logic [8:0] a);
    logic [1:0] s;
    s = a[1:0] + a[3:2] + a[5:4] + a[7:6] + {1'b0, a[8]};
    return s;
  endfunction

  function automatic logic [6:0] map_offset(input logic [8:0] a);
    return a[8:2];
  endfunction

endpackage

// File: rtl/coeff_unloader_if.sv
// Bank read port and output coefficient stream of the unloader.
//   bank_addr_0..3 / bank_ren : read request into the four data banks
//   bank_q_0..3               : bank read data, one cycle after bank_ren
//   dout_*                    : valid/ready coefficient stream, last on index 511
interface coeff_unloader_if #(
  parameter int unsigned data_width = 14,
  parameter int unsigned addr_width = 7
);
  logic [addr_width-1:0] bank_addr_0;
  logic [addr_width-1:0] bank_addr_1;
  logic [addr_width-1:0] bank_addr_2;
  logic [addr_width-1:0] bank_addr_3;
  logic [3:0]            bank_ren;
  logic [data_width-1:0] bank_q_0;
  logic [data_width-1:0] bank_q_1;
  logic [data_width-1:0] bank_q_2;
  logic [data_width-1:0] bank_q_3;
  logic [data_width-1:0] dout_data;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_last;

  modport master (
    output bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3, bank_ren,
    output dout_data, dout_valid, dout_last,
    input  bank_q_0, bank_q_1, bank_q_2, bank_q_3, dout_ready
  );

  modport slave (
    input  bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3, bank_ren,
    input  dout_data, dout_valid, dout_last,
    output bank_q_0, bank_q_1, bank_q_2, bank_q_3, dout_ready
  );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO with occupancy count; push and pop in the same cycle are
// both honoured, including a push into a full FIFO that is being popped.
//   push/push_data : write side
//   pop/pop_data   : read side, pop_data is the head entry ('0 when empty)
//   count          : current occupancy, valid : FIFO not empty
module stream_fifo #(
  parameter int unsigned width = 15,
  parameter int unsigned depth = 4,
  localparam int unsigned ptr_w = (depth > 1) ? $clog2(depth) : 1,
  localparam int unsigned cnt_w = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic [cnt_w-1:0] count,
  output logic             valid
);
  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign valid    = (count != '0);
  assign full     = (count == cnt_w'(depth));
  assign pop_ok   = pop && valid;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == ptr_w'(depth - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == ptr_w'(depth - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/coeff_unloader.sv
// Streams the 512 coefficients out of the four data banks in natural order.
// Each index is translated through the bank/offset memory map, read with one
// cycle latency and pushed into a skid FIFO that absorbs backpressure.
//   clk, rst : clock, synchronous active-high reset
//   start    : begins an unload (IDLE only)
//   busy     : unload in progress (through the done cycle)
//   done     : one-cycle pulse after the last beat is accepted
//   bus      : bank read port and output stream (master side)
module coeff_unloader
  import ntt_pkg::*;
#(
  parameter int unsigned data_width = ntt_data_width,
  parameter int unsigned addr_width = ntt_addr_width,
  parameter int unsigned n_coeff    = ntt_n_coeff,
  parameter int unsigned fifo_depth = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  coeff_unloader_if.master bus
);
  localparam int unsigned cnt_w = $clog2(fifo_depth + 1);

  unload_state_t         state, state_nxt;
  logic [9:0]            idx;
  logic                  last_idx;
  logic                  credit_ok;
  logic                  issue;
  logic                  rd_pend;
  logic                  rd_last;
  logic [1:0]            rd_bank;
  logic [data_width-1:0] q_sel;
  logic [cnt_w-1:0]      fifo_count;
  logic                  fifo_valid;
  logic [data_width:0]   fifo_out;
  logic                  pop;

  assign last_idx  = (idx[8:0] == 9'(n_coeff - 1));
  assign credit_ok = (int'(fifo_count) + int'(rd_pend)) <= (int'(fifo_depth) - 2);
  assign issue     = (state == READ) && credit_ok && !idx[9];
  assign pop       = fifo_valid && bus.dout_ready;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = READ;
      READ:  if (issue && last_idx) state_nxt = DRAIN;
      // Look through the pop of the final beat so done follows it directly.
      DRAIN: if (!rd_pend && (fifo_count == '0 || (fifo_count == cnt_w'(1) && pop)))
               state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      rd_pend <= 1'b0;
      rd_bank <= '0;
      rd_last <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= issue;
      if (state == IDLE && start) idx <= '0;
      else if (issue)             idx <= idx + 1'b1;
      if (issue) begin
        rd_bank <= map_bank(idx[8:0]);
        rd_last <= last_idx;
      end
    end
  end

  always_comb begin
    bus.bank_ren    = '0;
    bus.bank_addr_0 = '0;
    bus.bank_addr_1 = '0;
    bus.bank_addr_2 = '0;
    bus.bank_addr_3 = '0;
    if (issue) begin
      bus.bank_ren    = 4'(1) << map_bank(idx[8:0]);
      bus.bank_addr_0 = map_offset(idx[8:0]);
      bus.bank_addr_1 = map_offset(idx[8:0]);
      bus.bank_addr_2 = map_offset(idx[8:0]);
      bus.bank_addr_3 = map_offset(idx[8:0]);
    end
  end

  always_comb begin
    q_sel = '0;
    case (rd_bank)
      2'd0: q_sel = bus.bank_q_0;
      2'd1: q_sel = bus.bank_q_1;
      2'd2: q_sel = bus.bank_q_2;
      2'd3: q_sel = bus.bank_q_3;
      default: q_sel = '0;
    endcase
  end

  stream_fifo #(
    .width (data_width + 1),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_data ({rd_last, q_sel}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .count     (fifo_count),
    .valid     (fifo_valid)
  );

  assign bus.dout_valid = fifo_valid;
  assign bus.dout_last  = fifo_out[data_width];
  assign bus.dout_data  = fifo_out[data_width-1:0];
endmodule

// File: doc/coeff_unloader.md
# coeff_unloader

Streams the 512 coefficients of a finished NTT/INTT out of the four 14-bit data banks in natural order (index 0..511) over a valid/ready stream. It is the read-out end of the bank storage that the NTT datapath writes. It sits beside the core's bank ports, driving the bank address and read-enable inputs while the core is idle (after `done_flag`). It translates each natural index through the conflict-free memory map and absorbs downstream backpressure with a small skid FIFO.

## Interface
- `data_width`, 14, coefficient width
- `addr_width`, 7, per-bank address width
- `n_coeff`, 512, coefficients per polynomial
- `fifo_depth`, 4, output skid FIFO entries
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle pulse that begins an unload; sampled only in IDLE
- `busy` out 1: high from the cycle after `start` through the `done` cycle
- `done` out 1: one-cycle pulse after the last beat is accepted
- `bank_addr_0..3` out 7 each: bank read address; all four carry the same offset
- `bank_ren` out 4: one-hot read enable, bit b selects bank b
- `bank_q_0..3` in 14 each: bank read data, valid one cycle after `bank_ren`
- `dout_data` out 14: coefficient
- `dout_valid` out 1: beat present
- `dout_ready` in 1: sink accepts the beat when `dout_valid & dout_ready`
- `dout_last` out 1: high on the index-511 beat

## Operation
- Memory map for natural index a[8:0]:
  - offset = a[8:2]
  - bank = (a[1:0] + a[3:2] + a[5:4] + a[7:6] + {1'b0,a[8]}) mod 4
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE → READ on `start`. The index counter clears to 0.
  - READ issues one read per cycle when credit allows. On issuing index 511 it goes to DRAIN.
  - DRAIN → DONE when no read is in flight and the FIFO is empty.
  - DONE → IDLE unconditionally. `done`=1 only in DONE.
- Credit rule: issue a read only if FIFO count + in-flight reads ≤ `fifo_depth`−2. With `dout_ready` held high this sustains 1 beat/cycle.
- When no read is issued, `bank_ren` is 0.
- Read pipeline:
  - The bank number is registered alongside the issue.
  - The next cycle, `bank_q_<bank>` is pushed into the FIFO together with a last flag (index==511).
- FIFO output drives `dout_*`. A pop happens on `dout_valid & dout_ready`. Push and pop in the same cycle are both honoured, including when the FIFO is full with a pop pending.
- `start` during a non-IDLE state is ignored.
- `dout_data` holds stable while `dout_valid & !dout_ready`.
- The index counter is 10 bits so it cannot wrap past 511. No index beyond 511 is ever issued.

## Timing
- Reset values: `busy`=0, `done`=0, `bank_ren`=0, `bank_addr_*`=0, `dout_valid`=0, `dout_last`=0, `dout_data`=0. The FIFO is emptied and the counter is 0.
- Reset asserted mid-unload aborts immediately:
  - no `done` pulse;
  - next state is IDLE;
  - any in-flight read data is discarded.
- With `start` in cycle 0 and `dout_ready` held high:
  - first `bank_ren` in cycle 1;
  - first `dout_valid` in cycle 3 (bank latency 1 + FIFO register 1);
  - beat k appears in cycle 3+k;
  - `dout_last` in cycle 514;
  - `done` in cycle 515;
  - `busy` in cycles 1..515.
- Latency from issue to `dout_valid` is 2 cycles when the FIFO is empty.

## Structure
- Shared package `ntt_pkg` holds:
  - constants for data width (14), bank address width (7), coefficient count (512) and number of banks (4);
  - functions `map_bank(a)` and `map_offset(a)` implementing the memory map, so the loader and the NTT address path share them.
- One sub-module: `stream_fifo`, a parameterised synchronous FIFO with count output and same-cycle push/pop. Everything else (FSM, counter, credit, bank select) lives in `coeff_unloader`.

## Test plan
- Preload bank b offset o with {b,o} padded. Pulse `start` with `dout_ready`=1. Required: 512 beats in cycles 3..514.
  - Beat 5 = bank 2 offset 1.
  - Beat 256 = bank 1 offset 64.
  - Beat 511 = bank 1 offset 127 with `dout_last`=1.
  - `done` in cycle 515.
- Drive `dout_ready` with a random 30% duty cycle. Required: the same 512-value sequence, and no data change while stalled. FIFO count never exceeds 4.
- Hold `dout_ready`=0 for 20 cycles after `start`. Required: exactly 3 reads are issued, then `bank_ren` stays 0 until a pop.
- Pulse `start` again at beat 100. Required: ignored, and the sequence is unaffected.
- Assert `rst` at beat 200, then `start` again. Required: outputs return to their reset values in the cycle after `rst`, no `done` pulse, and the new unload restarts at index 0.
- Two back-to-back unloads, with `start` issued the cycle after `done`. Required: both complete with identical data.
